regfile_scoreboard: RTL

Parametrised multi-port register file, the next generation of the processor's 32x32 two-read/one-write register file with write-through forwarding and hardwired-zero register 0. It adds configurable width, depth and read/write port counts, an asynchronous clearing reset, and a per-register pending (scoreboard) bit so the decode stage can detect RAW hazards. It sits in the ID stage: the reads feed the operand latches, the writes come from WB, and issue comes from the decode/issue logic.

---
 rtl/regfile_scoreboard_pkg.sv | 12 +
 rtl/regfile_scoreboard_if.sv | 32 +++
 rtl/regfile_read_port.sv | 46 ++++
 rtl/regfile_scoreboard.sv | 101 ++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register file, decode and hazard units.
package regfile_scoreboard_pkg;

  parameter int unsigned DEF_DW     = 32;
  parameter int unsigned DEF_DEPTH  = 32;
  parameter int unsigned DEF_NUM_RD = 2;
  parameter int unsigned DEF_NUM_WR = 2;

  // Architectural zero register; reads as 0, never written, never pending.
  parameter int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read/write/issue bus between the ID-stage logic and the register file.
interface regfile_scoreboard_if #(
  parameter int unsigned DW     = regfile_scoreboard_pkg::DEF_DW,
  parameter int unsigned DEPTH  = regfile_scoreboard_pkg::DEF_DEPTH,
  parameter int unsigned NUM_RD = regfile_scoreboard_pkg::DEF_NUM_RD,
  parameter int unsigned NUM_WR = regfile_scoreboard_pkg::DEF_NUM_WR,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned CW     = $clog2(DEPTH + 1)
) ();

  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic [NUM_WR-1:0]    wr_en;
  logic [NUM_WR*AW-1:0] wr_addr;
  logic [NUM_WR*DW-1:0] wr_data;
  logic                 issue_en;
  logic [AW-1:0]        issue_addr;
  logic                 flush;
  logic [CW-1:0]        pending_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    input  rd_data, rd_busy, pending_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    output rd_data, rd_busy, pending_cnt
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: zero register, write-through forwarding, then storage.
module regfile_read_port
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned AW     = 5,
  parameter int unsigned NUM_WR = DEF_NUM_WR
) (
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        row,
  input  logic                 pending,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR*DW-1:0] wr_data,
  output logic [DW-1:0]        data,
  output logic                 busy
);

  logic          hit;
  logic [DW-1:0] fwd;

  // Ascending scan so the highest matching write port wins.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && (wr_addr[i*AW +: AW] == addr)) begin
        hit = 1'b1;
        fwd = wr_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    data = row;
    busy = pending;
    if (addr == AW'(REG_ZERO)) begin
      data = '0;
      busy = 1'b0;
    end else if (hit) begin
      data = fwd;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-through forwarding and per-register pending bits.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned NUM_RD = DEF_NUM_RD,
  parameter int unsigned NUM_WR = DEF_NUM_WR,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic [NUM_WR-1:0] wr_en_eff;
  logic [CW-1:0]    cnt;

  logic [NUM_RD-1:0][DW-1:0] rd_data_w;
  logic [NUM_RD-1:0]         rd_busy_w;

  // Forwarding must not leak write data onto the read ports while reset is held.
  assign wr_en_eff = bus.wr_en & {NUM_WR{~rst}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wr_en[i] && (bus.wr_addr[i*AW +: AW] != AW'(REG_ZERO))) begin
          mem_q[bus.wr_addr[i*AW +: AW]] <= bus.wr_data[i*DW +: DW];
        end
      end
    end
  end

  // Writeback clears first, then issue sets, so a new producer supersedes the completing one.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (bus.wr_en[i]) begin
        pending_d[bus.wr_addr[i*AW +: AW]] = 1'b0;
      end
    end
    if (bus.flush) begin
      pending_d = '0;
    end else if (bus.issue_en) begin
      pending_d[bus.issue_addr] = 1'b1;
    end
    pending_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int j = 0; j < DEPTH; j++) begin
      cnt = cnt + CW'(pending_q[j]);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr_k;
    logic [DW-1:0] row_k;

    assign addr_k = bus.rd_addr[k*AW +: AW];
    assign row_k  = mem_q[addr_k];

    regfile_read_port #(
      .DW     (DW),
      .AW     (AW),
      .NUM_WR (NUM_WR)
    ) u_rd_port (
      .addr    (addr_k),
      .row     (row_k),
      .pending (pending_q[addr_k]),
      .wr_en   (wr_en_eff),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .data    (rd_data_w[k]),
      .busy    (rd_busy_w[k])
    );
  end

  assign bus.rd_data     = rd_data_w;
  assign bus.rd_busy     = rd_busy_w;
  assign bus.pending_cnt = cnt;

endmodule
